sha_nonce_sched: RTL and testbench

- Sequencer in front of the pipelined SHA block.
- After a start command it issues one nonce per cycle into the pipeline's `en`/`nonce` inputs and counts how many nonces are in flight.
- It checks every hash that comes out of the pipeline against a 256-bit target, latches the first winning nonce, then drains the pipeline and reports done.

---
 rtl/sha_nonce_sched.sv | 128 ++++++++++++
 tb/tb_sha_nonce_sched.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_nonce_sched.sv
// rtl/sha_nonce_sched.sv - nonce issue sequencer and hit detector in front of the pipelined SHA block
module sha_nonce_sched #(
    parameter int WORD_S = 32,
    parameter int H_SIZE = 256,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_S-1:0] nonce_first,
    input  logic [WORD_S-1:0] nonce_last,
    input  logic [H_SIZE-1:0] target,
    output logic              pipe_en,
    output logic [WORD_S-1:0] pipe_nonce,
    input  logic              pipe_en_next,
    input  logic [WORD_S-1:0] pipe_nonce_out,
    input  logic [H_SIZE-1:0] pipe_H,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [WORD_S-1:0] found_nonce,
    output logic              exhausted
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nx;
    logic [WORD_S-1:0] next_nonce;
    logic [WORD_S-1:0] last_q;
    logic [H_SIZE-1:0] target_q;
    logic              abort_seen;
    logic              active;
    logic              hit;

    // First hit of the current run and the in-flight count after this cycle's issue/retire.
    // A result with nothing in flight is a protocol error: the count saturates at zero.
    always_comb begin
        active = (state == S_ISSUE) || (state == S_DRAIN);
        hit    = active && pipe_en_next && !found && (pipe_H < target_q);
        cnt_nx = cnt;
        if (pipe_en && !pipe_en_next) begin
            cnt_nx = cnt + CNT_W'(1);
        end else if (!pipe_en && pipe_en_next && (cnt != '0)) begin
            cnt_nx = cnt - CNT_W'(1);
        end
    end

    // Control FSM with registered pipeline and status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            pipe_en     <= 1'b0;
            pipe_nonce  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            found       <= 1'b0;
            found_nonce <= '0;
            exhausted   <= 1'b0;
            cnt         <= '0;
            next_nonce  <= '0;
            last_q      <= '0;
            target_q    <= '0;
            abort_seen  <= 1'b0;
        end else begin
            cnt  <= cnt_nx;
            done <= 1'b0;
            if (hit) begin
                found       <= 1'b1;
                found_nonce <= pipe_nonce_out;
            end
            case (state)
                S_IDLE, S_DONE: begin
                    pipe_en <= 1'b0;
                    if (start) begin
                        last_q     <= nonce_last;
                        target_q   <= target;
                        next_nonce <= nonce_first;
                        found      <= 1'b0;
                        exhausted  <= 1'b0;
                        abort_seen <= 1'b0;
                        busy       <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (abort) begin
                        abort_seen <= 1'b1;
                    end
                    if (hit || abort) begin
                        // The nonce on the bus this cycle is already counted; stop after it.
                        pipe_en <= 1'b0;
                        state   <= S_DRAIN;
                    end else begin
                        pipe_en    <= 1'b1;
                        pipe_nonce <= next_nonce;
                        next_nonce <= next_nonce + WORD_S'(1);
                        // Wrapping past all-ones is legal, so only equality ends the range.
                        if (next_nonce == last_q) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    pipe_en <= 1'b0;
                    if (abort) begin
                        abort_seen <= 1'b1;
                    end
                    if (cnt_nx == '0) begin
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        exhausted <= !(found || hit) && !(abort_seen || abort);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha_nonce_sched.sv
// tb/tb_sha_nonce_sched.sv - scoreboard bench for sha_nonce_sched with a latency-configurable pipeline model
module tb_sha_nonce_sched;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [31:0]  nonce_first = '0;
    logic [31:0]  nonce_last = '0;
    logic [255:0] target = '0;
    logic         pipe_en;
    logic [31:0]  pipe_nonce;
    logic         pipe_en_next = 1'b0;
    logic [31:0]  pipe_nonce_out = '0;
    logic [255:0] pipe_H = '0;
    logic         busy;
    logic         done;
    logic         found;
    logic [31:0]  found_nonce;
    logic         exhausted;

    sha_nonce_sched #(.WORD_S(32), .H_SIZE(256), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .nonce_first(nonce_first), .nonce_last(nonce_last), .target(target),
        .pipe_en(pipe_en), .pipe_nonce(pipe_nonce),
        .pipe_en_next(pipe_en_next), .pipe_nonce_out(pipe_nonce_out), .pipe_H(pipe_H),
        .busy(busy), .done(done), .found(found), .found_nonce(found_nonce), .exhausted(exhausted)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        found;
        bit [31:0] fn;
        bit        exh;
    } comp_t;

    typedef struct {
        bit         en;
        bit [31:0]  n;
        bit [255:0] h;
    } pent_t;

    int           n_checks = 0;
    int           n_pass = 0;
    bit [31:0]    exp_issue[$];
    comp_t        exp_done[$];
    pent_t        pq[$];
    bit [255:0]   hmap[bit [31:0]];
    int           neg_cnt = 0;
    int           last_res_neg = -100;
    int           res_cnt = 0;
    int           done_cnt = 0;
    int           issued_total = 0;
    int           abort_target = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic bit [255:0] hash_of(input bit [31:0] n);
        return hmap.exists(n) ? hmap[n] : {256{1'b1}};
    endfunction

    function automatic bit [255:0] rand256();
        bit [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Monitor, SHA pipeline model and abort driver, all sampled mid-cycle.
    always @(negedge clk) begin
        pent_t e;
        pent_t o;
        comp_t c;
        neg_cnt++;
        if (pipe_en === 1'b1) begin
            issued_total++;
            check("busy_while_issuing", busy, 1);
            if (exp_issue.size() == 0) begin
                check("unexpected_issue", pipe_nonce, 'x);
            end else begin
                check("issued_nonce", pipe_nonce, exp_issue.pop_front());
            end
        end
        if (done === 1'b1) begin
            done_cnt++;
            if (exp_done.size() == 0) begin
                check("unexpected_done", done, 0);
            end else begin
                c = exp_done.pop_front();
                check("found", found, c.found);
                if (c.found) check("found_nonce", found_nonce, c.fn);
                check("exhausted", exhausted, c.exh);
                check("busy_at_done", busy, 0);
                check("missing_issues", exp_issue.size(), 0);
                check("done_after_last_result", neg_cnt, last_res_neg + 1);
            end
        end
        e.en = (pipe_en === 1'b1);
        e.n  = pipe_nonce;
        e.h  = hash_of(pipe_nonce);
        pq.push_back(e);
        o = pq.pop_front();
        pipe_en_next   = o.en;
        pipe_nonce_out = o.en ? o.n : 32'h0;
        pipe_H         = o.en ? o.h : 256'h0;
        if (o.en) begin
            res_cnt++;
            last_res_neg = neg_cnt;
        end
        abort = (abort_target != 0) && (pipe_en === 1'b1) && (issued_total == abort_target);
    end

    task automatic set_lat(input int lat);
        pent_t z;
        z.en = 0; z.n = 0; z.h = 0;
        pq.delete();
        repeat (lat) pq.push_back(z);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_pipe_en"}, pipe_en, 0);
        check({tag, "_pipe_nonce"}, pipe_nonce, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_found"}, found, 0);
        check({tag, "_found_nonce"}, found_nonce, 0);
        check({tag, "_exhausted"}, exhausted, 0);
    endtask

    // Reference: results return in issue order, so the first hit in range order wins;
    // a hit seen L cycles after issue i stops issuing after index i+L, abort after its own index.
    task automatic predict(input bit [31:0] first, input bit [31:0] last, input bit [255:0] tgt,
                           input int lat, input int abort_idx, input bit want_done);
        bit [31:0] d;
        int        n;
        int        stop;
        int        hit_i;
        bit        ab;
        comp_t     c;
        d = last - first;
        n = int'(d) + 1;
        stop = n;
        hit_i = -1;
        for (int i = 0; i < n; i++) begin
            if (hash_of(first + 32'(i)) < tgt) begin
                hit_i = i;
                break;
            end
        end
        if (hit_i >= 0 && hit_i + lat + 1 < stop) stop = hit_i + lat + 1;
        ab = (abort_idx != 0) && (abort_idx <= stop);
        if (ab) stop = abort_idx;
        for (int i = 0; i < stop; i++) exp_issue.push_back(first + 32'(i));
        c.found = (hit_i >= 0) && (hit_i < stop);
        c.fn    = c.found ? first + 32'(hit_i) : 32'h0;
        c.exh   = !c.found && !ab;
        if (want_done) exp_done.push_back(c);
    endtask

    task automatic kick(input bit [31:0] first, input bit [31:0] last, input bit [255:0] tgt,
                        input int abort_idx);
        @(negedge clk);
        abort_target = (abort_idx != 0) ? issued_total + abort_idx : 0;
        nonce_first = first;
        nonce_last  = last;
        target      = tgt;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        nonce_first = $urandom;
        nonce_last  = $urandom;
        target      = '0;
        start       = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input bit [31:0] first, input bit [31:0] last, input bit [255:0] tgt,
                       input int lat, input int abort_idx);
        int d0;
        int k;
        set_lat(lat);
        predict(first, last, tgt, lat, abort_idx, 1'b1);
        d0 = done_cnt;
        kick(first, last, tgt, abort_idx);
        k = 0;
        while (done_cnt == d0 && k < lat + 400) begin
            @(negedge clk);
            k++;
        end
        if (done_cnt == d0) begin
            check("done_timeout", done_cnt, d0 + 1);
            exp_issue.delete();
            exp_done.delete();
        end
        repeat (3) @(negedge clk);
        abort_target = 0;
    endtask

    initial begin
        bit [31:0]  f;
        bit [255:0] t;
        int         nn;
        int         r0;
        int         k;
        set_lat(66);
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        // No hit possible with target 0.
        run(32'h10, 32'h17, 256'h0, 66, 0);
        // Single hit; long latency so the whole range is issued anyway.
        hmap[32'h13] = 256'h0;
        run(32'h10, 32'h17, {256{1'b1}}, 66, 0);
        // Same hit with short latency: issuing stops the cycle after the hit is seen.
        run(32'h10, 32'h3F, {256{1'b1}}, 3, 0);
        hmap.delete();
        // Wrapped range.
        run(32'hFFFF_FFFE, 32'h0000_0001, 256'h0, 66, 0);
        // Single-nonce range.
        run(32'h5, 32'h5, 256'h0, 66, 0);
        // Abort on the third issue of a 100-nonce range.
        run(32'h100, 32'h163, 256'h0, 10, 3);
        // Two consecutive hits: the first one sticks.
        hmap[32'h20] = 256'h0;
        hmap[32'h21] = 256'h0;
        run(32'h1E, 32'h25, {256{1'b1}}, 4, 0);
        hmap.delete();
        // Comparator boundary: H == target is not a hit, H == target-1 is.
        t = rand256() | 256'h1;
        hmap[32'h42] = t;
        hmap[32'h45] = t - 256'h1;
        run(32'h40, 32'h47, t, 5, 0);
        hmap.delete();

        // Randomised ranges, hashes, targets, latencies and aborts.
        for (int it = 0; it < 12; it++) begin
            f  = $urandom;
            nn = $urandom_range(1, 40);
            for (int i = 0; i < nn; i++) begin
                if ($urandom_range(0, 3) == 0) hmap[f + 32'(i)] = rand256();
            end
            run(f, f + 32'(nn - 1), rand256(), $urandom_range(2, 20),
                ($urandom_range(0, 2) == 0) ? $urandom_range(1, nn) : 0);
            hmap.delete();
        end

        // Reset while ten results are still in flight; the late hits must be ignored.
        set_lat(66);
        for (int i = 10; i < 20; i++) hmap[32'h30 + 32'(i)] = 256'h0;
        predict(32'h30, 32'h43, {256{1'b1}}, 66, 0, 1'b0);
        r0 = res_cnt;
        kick(32'h30, 32'h43, {256{1'b1}}, 0);
        k = 0;
        while (res_cnt - r0 < 10 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("reset_test_results_reached", res_cnt - r0, 10);
        check("reset_test_issued_all", exp_issue.size(), 0);
        exp_issue.delete();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle_outputs("midreset");
        repeat (75) @(negedge clk);
        check("late_results_found", found, 0);
        check("late_results_busy", busy, 0);
        hmap.delete();
        // A fresh start after the reset behaves normally.
        run(32'h10, 32'h17, 256'h0, 66, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
